mem_store_buf: RTL and testbench
================================

// Module: mem_store_buf
// PURPOSE
//  Store buffer between the MEM stage and the data RAM. MEM-stage stores are queued
//  in a small FIFO and written to RAM through a req/ack port, so slow RAM writes do
//  not stall the pipeline until the FIFO is full. MEM-stage loads read RAM directly.
//  A load that hits a queued store gets its data from the FIFO instead.
// PARAMETERS
//  ADDR_W   10  word-address width (matches MEM-stage mem_addr)
//  DATA_W   32  data word width
//  SB_DEPTH 4   FIFO entries; power of two, >=2
// PORTS
//  clk          in  1       system clock, rising edge
//  rst          in  1       asynchronous, active-low reset
//  mem_addr_i   in  ADDR_W  word address from MEM stage (load or store)
//  mem_we_i     in  1       store request (SW)
//  mem_re_i     in  1       load request (LW); never asserted together with mem_we_i
//  mem_wdata_i  in  DATA_W  store data
//  mem_rdata_o  out DATA_W  load data to MEM stage, combinational
//  stall_req_o  out 1       store not accepted this cycle; upstream holds the store
//  ram_raddr_o  out ADDR_W  RAM asynchronous read address
//  ram_rdata_i  in  DATA_W  RAM read data, same cycle
//  ram_wreq_o   out 1       RAM write request
//  ram_waddr_o  out ADDR_W  RAM write address (head entry)
//  ram_wdata_o  out DATA_W  RAM write data (head entry)
//  ram_wack_i   in  1       RAM accepted the write, sampled on the rising edge
//  sb_count_o   out clog2(SB_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset (rst=0, async): pointers and count cleared, all entry valid bits cleared.
//    Pending stores are discarded, including on reset mid-drain.
//    stall_req_o, ram_wreq_o, sb_count_o = 0. ram_waddr_o, ram_wdata_o = 0.
//    mem_rdata_o = 0 and ram_raddr_o = 0 while rst=0. Entry data is not reset.
//  - Push: on the edge where mem_we_i=1 and count<SB_DEPTH, {addr,data} is written at wr_ptr.
//    wr_ptr increments mod SB_DEPTH. Latency of 1 cycle before the entry is visible.
//  - Full: stall_req_o = mem_we_i & (count==SB_DEPTH), combinational. The check is
//    conservative: stall is asserted even if an ack arrives that same cycle.
//  - Drain FSM with states IDLE and WAIT_ACK.
//    IDLE: when count!=0, go to WAIT_ACK.
//    WAIT_ACK: ram_wreq_o=1; ram_waddr_o/ram_wdata_o show the head entry, held stable.
//      On ram_wack_i=1: pop head and increment rd_ptr mod SB_DEPTH.
//      Then stay in WAIT_ACK if entries remain (back-to-back), else go to IDLE.
//    ram_wack_i is ignored in IDLE. Writes reach RAM strictly in FIFO order.
//  - Simultaneous push+pop: both pointers advance and the count is unchanged.
//  - Load: ram_raddr_o = mem_addr_i.
//    mem_rdata_o = data of the YOUNGEST valid entry with addr==mem_addr_i; if none
//    matches, mem_rdata_o = ram_rdata_i.
//    The head entry still matches in its ack cycle; it is removed only at the edge.
//    With mem_re_i=0, mem_rdata_o = ram_rdata_i (don't-care to MEM stage).
//  - Count width is clog2(SB_DEPTH)+1 so that full and empty are distinct.
// STRUCTURE
//  - defines.v: `SbDepth, `SbIdle/`SbWaitAck state codes, reuse `RstEnable/`WriteEnable.
//  - Sub-module sb_fwd_match: combinational age-ordered address compare.
//    Takes the per-entry valid/addr/data vectors, rd_ptr and the load address.
//    Returns hit and forwarded data.
//  - Top level holds the entry registers, pointers, count and drain FSM.
// TESTING
//  1. Reset with 3 entries queued and ram_wreq_o=1 -> next cycle count=0, ram_wreq_o=0,
//     stall_req_o=0; a later load to one of those addresses returns ram_rdata_i.
//  2. SW 0x010<-0xDEADBEEF with ack low; next cycle LW 0x010, ram_rdata_i=0x0
//     -> mem_rdata_o=0xDEADBEEF.
//  3. SW 0x020<-0x1, SW 0x020<-0x2, ack low; LW 0x020 -> mem_rdata_o=0x2 (youngest).
//  4. Four stores with ack low -> count=4. A 5th store -> stall_req_o=1.
//     One ack pulse -> count=3, then the held 5th store is accepted (count=4).
//  5. ack tied high, stores to A0..A3 on consecutive cycles -> one RAM write per cycle,
//     issued in the order A0,A1,A2,A3; FSM returns to IDLE when empty.
//  6. count=2, push+ack in the same cycle -> count stays 2; 6 total pushes wrap wr_ptr
//     and data order at RAM stays correct.

Source files
------------

// File: rtl/mem_store_buf_pkg.sv
// Shared types and defaults for the MEM-stage store buffer.
package mem_store_buf_pkg;

  localparam int unsigned SB_ADDR_W_DEF = 10;
  localparam int unsigned SB_DATA_W_DEF = 32;
  localparam int unsigned SB_DEPTH_DEF  = 4;

  typedef enum logic {
    SB_IDLE     = 1'b0,
    SB_WAIT_ACK = 1'b1
  } sb_state_e;

  function automatic int unsigned sb_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_store_buf_fwd_match.sv
// Age-ordered address compare over the queued stores; the youngest matching entry wins.
module mem_store_buf_fwd_match
  import mem_store_buf_pkg::*;
#(
  parameter int unsigned ADDR_W   = SB_ADDR_W_DEF,
  parameter int unsigned DATA_W   = SB_DATA_W_DEF,
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic [SB_DEPTH-1:0]             ent_valid,
  input  logic [SB_DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [SB_DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [$clog2(SB_DEPTH)-1:0]     rd_ptr,
  input  logic [ADDR_W-1:0]               ld_addr,
  output logic                            fwd_hit_c,
  output logic [DATA_W-1:0]               fwd_data_c
);

  localparam int unsigned PTR_W = sb_ptr_w(SB_DEPTH);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit_c  = 1'b0;
    fwd_data_c = '0;
    idx        = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if (ent_valid[idx] && (ent_addr[idx] == ld_addr)) begin
        fwd_hit_c  = 1'b1;
        fwd_data_c = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/mem_store_buf.sv
// Store buffer between MEM stage and data RAM: queues stores, drains via req/ack,
// forwards queued store data to matching loads.
module mem_store_buf
  import mem_store_buf_pkg::*;
#(
  parameter int unsigned ADDR_W   = SB_ADDR_W_DEF,
  parameter int unsigned DATA_W   = SB_DATA_W_DEF,
  parameter int unsigned SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           mem_addr_i,
  input  logic                        mem_we_i,
  input  logic                        mem_re_i,
  input  logic [DATA_W-1:0]           mem_wdata_i,
  output logic [DATA_W-1:0]           mem_rdata_o,
  output logic                        stall_req_o,
  output logic [ADDR_W-1:0]           ram_raddr_o,
  input  logic [DATA_W-1:0]           ram_rdata_i,
  output logic                        ram_wreq_o,
  output logic [ADDR_W-1:0]           ram_waddr_o,
  output logic [DATA_W-1:0]           ram_wdata_o,
  input  logic                        ram_wack_i,
  output logic [$clog2(SB_DEPTH):0]   sb_count_o
);

  localparam int unsigned PTR_W = sb_ptr_w(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [SB_DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [SB_DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [SB_DEPTH-1:0]             ent_valid_q, ent_valid_d;
  logic [PTR_W-1:0]                wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]                count_q, count_d;
  sb_state_e                       state_q, state_d;

  logic                            full;
  logic                            push;
  logic                            pop;
  logic                            fwd_hit;
  logic [DATA_W-1:0]               fwd_data;

  assign full  = (count_q == CNT_W'(SB_DEPTH));
  assign push  = mem_we_i && !full;
  assign pop   = (state_q == SB_WAIT_ACK) && ram_wack_i;

  // Full check ignores a same-cycle ack on purpose.
  assign stall_req_o = mem_we_i && full;

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    ent_valid_d = ent_valid_q;
    if (pop) begin
      ent_valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      ent_valid_d[wr_ptr_q] = 1'b1;
    end
  end

  // Drain FSM next state; stays in WAIT_ACK while entries remain after this edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE: begin
        if (count_q != '0) begin
          state_d = SB_WAIT_ACK;
        end
      end
      SB_WAIT_ACK: begin
        if (count_d == '0) begin
          state_d = SB_IDLE;
        end
      end
      default: state_d = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SB_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ent_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ent_valid_q <= ent_valid_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Entry payload carries no reset; the valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr_q] <= mem_addr_i;
      ent_data[wr_ptr_q] <= mem_wdata_i;
    end
  end

  mem_store_buf_fwd_match #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .SB_DEPTH (SB_DEPTH)
  ) u_fwd_match (
    .ent_valid  (ent_valid_q),
    .ent_addr   (ent_addr),
    .ent_data   (ent_data),
    .rd_ptr     (rd_ptr_q),
    .ld_addr    (mem_addr_i),
    .fwd_hit_c  (fwd_hit),
    .fwd_data_c (fwd_data)
  );

  // Head entry cannot be overwritten while requested, so these stay stable until ack.
  assign ram_wreq_o  = (state_q == SB_WAIT_ACK);
  assign ram_waddr_o = ram_wreq_o ? ent_addr[rd_ptr_q] : '0;
  assign ram_wdata_o = ram_wreq_o ? ent_data[rd_ptr_q] : '0;
  assign sb_count_o  = count_q;

  assign ram_raddr_o = rst ? mem_addr_i : '0;
  assign mem_rdata_o = !rst                   ? '0       :
                       (mem_re_i && fwd_hit)  ? fwd_data :
                                                ram_rdata_i;

endmodule

// File: tb/tb_mem_store_buf.sv
// Directed bench for mem_store_buf with a store-order scoreboard and forwarding model.
module tb_mem_store_buf;

  localparam int unsigned AW    = 10;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] mem_addr_i = '0;
  logic          mem_we_i = 1'b0;
  logic          mem_re_i = 1'b0;
  logic [DW-1:0] mem_wdata_i = '0;
  logic [DW-1:0] mem_rdata_o;
  logic          stall_req_o;
  logic [AW-1:0] ram_raddr_o;
  logic [DW-1:0] ram_rdata_i = '0;
  logic          ram_wreq_o;
  logic [AW-1:0] ram_waddr_o;
  logic [DW-1:0] ram_wdata_o;
  logic          ram_wack_i = 1'b0;
  logic [2:0]    sb_count_o;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          sb_q[$];
  logic [AW-1:0] wr_log[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            n_wr  = 0;

  mem_store_buf #(.ADDR_W(AW), .DATA_W(DW), .SB_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr_i  (mem_addr_i),
    .mem_we_i    (mem_we_i),
    .mem_re_i    (mem_re_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .stall_req_o (stall_req_o),
    .ram_raddr_o (ram_raddr_o),
    .ram_rdata_i (ram_rdata_i),
    .ram_wreq_o  (ram_wreq_o),
    .ram_waddr_o (ram_waddr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_wack_i  (ram_wack_i),
    .sb_count_o  (sb_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rdata();
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].a == mem_addr_i) return sb_q[i].d;
    end
    return ram_rdata_i;
  endfunction

  task automatic drive(input bit we, input bit re, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_we_i    = we;
    mem_re_i    = re;
    mem_addr_i  = a;
    mem_wdata_i = d;
  endtask

  // One clock: check combinational outputs, update the model, advance, check count.
  task automatic tick();
    bit accept;
    #1;
    accept = mem_we_i && (sb_q.size() < DEPTH);
    chk("stall", 64'(stall_req_o), 64'(mem_we_i && (sb_q.size() == DEPTH)));
    chk("raddr", 64'(ram_raddr_o), 64'(mem_addr_i));
    if (mem_re_i) chk("load", 64'(mem_rdata_o), 64'(model_rdata()));
    if (ram_wreq_o) begin
      chk("wr_pending", 64'(sb_q.size() != 0), 64'(1));
      if (sb_q.size() != 0) begin
        chk("waddr", 64'(ram_waddr_o), 64'(sb_q[0].a));
        chk("wdata", 64'(ram_wdata_o), 64'(sb_q[0].d));
        if (ram_wack_i) begin
          wr_log.push_back(ram_waddr_o);
          void'(sb_q.pop_front());
          n_wr++;
        end
      end
    end
    if (accept) sb_q.push_back('{a: mem_addr_i, d: mem_wdata_i});
    @(posedge clk);
    #1;
    chk("count", 64'(sb_count_o), 64'(sb_q.size()));
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    drive(1'b1, 1'b0, a, d);
    tick();
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1, 10'h3FF, 32'h1234_5678);
    ram_rdata_i = 32'hFFFF_FFFF;
    rst = 1'b0;
    sb_q.delete();
    #1;
    chk("rst_wreq",  64'(ram_wreq_o),  64'(0));
    chk("rst_count", 64'(sb_count_o),  64'(0));
    chk("rst_stall", 64'(stall_req_o), 64'(0));
    chk("rst_rdata", 64'(mem_rdata_o), 64'(0));
    chk("rst_raddr", 64'(ram_raddr_o), 64'(0));
    chk("rst_waddr", 64'(ram_waddr_o), 64'(0));
    chk("rst_wdata", 64'(ram_wdata_o), 64'(0));
    @(posedge clk);
    #1;
    chk("rst_count_hold", 64'(sb_count_o), 64'(0));
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    ram_rdata_i = '0;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, '0, '0);
    ram_wack_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && !ram_wreq_o) break;
      tick();
    end
    chk("drain_wreq", 64'(ram_wreq_o), 64'(0));
    ram_wack_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset mid-drain discards three queued stores.
    ram_wack_i = 1'b0;
    store(10'h100, 32'h0000_0011);
    store(10'h101, 32'h0000_0022);
    store(10'h102, 32'h0000_0033);
    idle();
    chk("t1_wreq_before", 64'(ram_wreq_o), 64'(1));
    do_reset();
    ram_rdata_i = 32'h5555_AAAA;
    drive(1'b0, 1'b1, 10'h101, '0);
    #1;
    chk("t1_load_ram", 64'(mem_rdata_o), 64'(32'h5555_AAAA));
    tick();
    idle();

    // Forward a queued store to a following load.
    store(10'h010, 32'hDEAD_BEEF);
    ram_rdata_i = 32'h0;
    drive(1'b0, 1'b1, 10'h010, '0);
    #1;
    chk("t2_fwd", 64'(mem_rdata_o), 64'(32'hDEAD_BEEF));
    tick();

    // Youngest of two same-address stores wins.
    do_reset();
    store(10'h020, 32'h1);
    store(10'h020, 32'h2);
    ram_rdata_i = 32'h7777_7777;
    drive(1'b0, 1'b1, 10'h020, '0);
    #1;
    chk("t3_youngest", 64'(mem_rdata_o), 64'(32'h2));
    tick();

    // Full buffer stalls, one ack frees a slot for the held store.
    do_reset();
    for (int i = 0; i < 4; i++) store(AW'(10'h030 + i), DW'(32'hC000_0000 + i));
    chk("t4_full", 64'(sb_count_o), 64'(4));
    drive(1'b1, 1'b0, 10'h034, 32'hC000_0004);
    #1;
    chk("t4_stall", 64'(stall_req_o), 64'(1));
    tick();
    ram_wack_i = 1'b1;
    tick();
    ram_wack_i = 1'b0;
    chk("t4_after_ack", 64'(sb_count_o), 64'(3));
    tick();
    chk("t4_refill", 64'(sb_count_o), 64'(4));
    drain();

    // Ack tied high: back-to-back writes in FIFO order, then idle.
    do_reset();
    wr_log.delete();
    n_wr = 0;
    ram_wack_i = 1'b1;
    for (int i = 0; i < 4; i++) store(AW'(10'h040 + i), DW'(32'hA000_0040 + i));
    idle();
    idle();
    chk("t5_writes", 64'(n_wr), 64'(4));
    chk("t5_idle", 64'(ram_wreq_o), 64'(0));
    for (int i = 0; i < 4; i++) chk("t5_order", 64'(wr_log[i]), 64'(10'h040 + i));
    ram_wack_i = 1'b0;

    // Push and pop together hold the count; six pushes wrap the pointers.
    do_reset();
    wr_log.delete();
    store(10'h050, 32'hB000_0050);
    store(10'h051, 32'hB000_0051);
    idle();
    ram_wack_i = 1'b1;
    for (int i = 2; i < 6; i++) begin
      store(AW'(10'h050 + i), DW'(32'hB000_0050 + i));
      chk("t6_count_steady", 64'(sb_count_o), 64'(2));
    end
    drain();
    chk("t6_writes", 64'(wr_log.size()), 64'(6));
    for (int i = 0; i < 6; i++) begin
      if (i < wr_log.size()) chk("t6_order", 64'(wr_log[i]), 64'(10'h050 + i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
